// File: rtl/pb_event_decoder_if.sv
// Push-button event bus: debounced button inputs toward the decoder, registered events back.
// The decoder connects through the slave modport; the button source/consumer uses master.
interface pb_event_decoder_if;
   logic       PB_STATE;
   logic       PB_DOWN;
   logic       PRESS_P;
   logic       RELEASE_P;
   logic       SHORT_P;
   logic       LONG_P;
   logic       REPEAT_P;
   logic       HOLD;
   logic [7:0] PRESS_CNT;

   modport master (
      output PB_STATE,
      output PB_DOWN,
      input  PRESS_P,
      input  RELEASE_P,
      input  SHORT_P,
      input  LONG_P,
      input  REPEAT_P,
      input  HOLD,
      input  PRESS_CNT
   );

   modport slave (
      input  PB_STATE,
      input  PB_DOWN,
      output PRESS_P,
      output RELEASE_P,
      output SHORT_P,
      output LONG_P,
      output REPEAT_P,
      output HOLD,
      output PRESS_CNT
   );
endinterface

// File: rtl/pb_event_decoder.sv
// Push-button event decoder: press/release/short/long pulses, hold level and press counter.
// Define PB_AUTO_REPEAT_EN to build the auto-repeat counter that drives REPEAT_P while long-held.
module pb_event_decoder #(
   parameter int unsigned LONG_CYCLES   = 1000,
   parameter int unsigned REPEAT_CYCLES = 200
) (
   input  logic                CLK,
   input  logic                RESETn,
   pb_event_decoder_if.slave   pb
);

   typedef enum logic [1:0] {
      StIdle,
      StPressed,
      StLong
   } state_e;

   localparam logic [15:0] LongLast = 16'(LONG_CYCLES - 1);

   if (LONG_CYCLES < 2 || LONG_CYCLES > 65535 ||
       REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : gen_param_err
      $error("pb_event_decoder: LONG_CYCLES or REPEAT_CYCLES out of legal range");
   end

   state_e      state_q, state_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic [15:0] hold_cnt_inc;
   logic [7:0]  press_cnt_q, press_cnt_d;
   logic        press_p_q, press_p_d;
   logic        release_p_q, release_p_d;
   logic        short_p_q, short_p_d;
   logic        long_p_q, long_p_d;
   logic        repeat_p_q, repeat_p_d;
   logic        hold_q, hold_d;
   logic        pressed;

   // A debouncer mismatch between level and flag is deliberately read as released.
   assign pressed = pb.PB_DOWN & ~pb.PB_STATE;

   assign hold_cnt_inc = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      press_cnt_d = press_cnt_q;
      press_p_d   = 1'b0;
      release_p_d = 1'b0;
      short_p_d   = 1'b0;
      long_p_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pressed) begin
               state_d     = StPressed;
               press_p_d   = 1'b1;
               hold_cnt_d  = 16'd0;
               press_cnt_d = press_cnt_q + 8'd1;
            end
         end
         StPressed: begin
            // Release takes priority over a threshold hit on the same edge.
            if (!pressed) begin
               state_d     = StIdle;
               release_p_d = 1'b1;
               short_p_d   = 1'b1;
            end else if (hold_cnt_q == LongLast) begin
               state_d    = StLong;
               long_p_d   = 1'b1;
               hold_cnt_d = hold_cnt_inc;
            end else begin
               hold_cnt_d = hold_cnt_inc;
            end
         end
         StLong: begin
            if (!pressed) begin
               state_d     = StIdle;
               release_p_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_inc;
            end
         end
         default: state_d = StIdle;
      endcase

      hold_d = (state_d != StIdle);
   end

`ifdef PB_AUTO_REPEAT_EN
   localparam logic [15:0] RepeatLast = 16'(REPEAT_CYCLES - 1);

   logic [15:0] rep_cnt_q, rep_cnt_d;

   always_comb begin
      rep_cnt_d  = rep_cnt_q;
      repeat_p_d = 1'b0;
      if (state_q == StPressed && state_d == StLong) begin
         rep_cnt_d = 16'd0;
      end else if (state_q == StLong && pressed) begin
         if (rep_cnt_q == RepeatLast) begin
            repeat_p_d = 1'b1;
            rep_cnt_d  = 16'd0;
         end else begin
            rep_cnt_d = rep_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         rep_cnt_q <= 16'd0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end
`else
   assign repeat_p_d = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= StIdle;
         hold_cnt_q  <= 16'd0;
         press_cnt_q <= 8'd0;
         press_p_q   <= 1'b0;
         release_p_q <= 1'b0;
         short_p_q   <= 1'b0;
         long_p_q    <= 1'b0;
         repeat_p_q  <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         press_cnt_q <= press_cnt_d;
         press_p_q   <= press_p_d;
         release_p_q <= release_p_d;
         short_p_q   <= short_p_d;
         long_p_q    <= long_p_d;
         repeat_p_q  <= repeat_p_d;
         hold_q      <= hold_d;
      end
   end

   assign pb.PRESS_P   = press_p_q;
   assign pb.RELEASE_P = release_p_q;
   assign pb.SHORT_P   = short_p_q;
   assign pb.LONG_P    = long_p_q;
   assign pb.REPEAT_P  = repeat_p_q;
   assign pb.HOLD      = hold_q;
   assign pb.PRESS_CNT = press_cnt_q;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Directed bench for pb_event_decoder with LONG_CYCLES=10, REPEAT_CYCLES=4.
// Repeat expectations follow whether PB_AUTO_REPEAT_EN is defined for the build.
module tb_pb_event_decoder;

   localparam int L = 10;
   localparam int R = 4;
`ifdef PB_AUTO_REPEAT_EN
   localparam bit RepEn = 1'b1;
`else
   localparam bit RepEn = 1'b0;
`endif

   logic CLK;
   logic RESETn;
   int   checks;
   int   errors;

   pb_event_decoder_if pb_if ();

   pb_event_decoder #(
      .LONG_CYCLES   (L),
      .REPEAT_CYCLES (R)
   ) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .pb     (pb_if)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Output vector order: {PRESS_P, RELEASE_P, SHORT_P, LONG_P, REPEAT_P, HOLD}
   function automatic logic [5:0] outs();
      return {pb_if.PRESS_P, pb_if.RELEASE_P, pb_if.SHORT_P,
              pb_if.LONG_P, pb_if.REPEAT_P, pb_if.HOLD};
   endfunction

   task automatic chk_outs(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = outs();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [7:0] exp);
      checks++;
      assert (pb_if.PRESS_CNT === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, pb_if.PRESS_CNT, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_in(input logic state, input logic down);
      pb_if.PB_STATE = state;
      pb_if.PB_DOWN  = down;
   endtask

   // Press sampled on n edges, released on edge n; checks every cycle of the timeline.
   task automatic press_seq(input string tag, input int n, input logic [7:0] cnt_after);
      logic [5:0] e;
      set_in(1'b0, 1'b1);
      for (int k = 0; k <= n; k++) begin
         step();
         e[5] = (k == 0);
         e[4] = (k == n);
         e[3] = (k == n) && (n <= L);
         e[2] = (k == L) && (k < n);
         e[1] = RepEn && (k > L) && (k < n) && (((k - L) % R) == 0);
         e[0] = (k < n);
         chk_outs($sformatf("%s_k%0d", tag, k), e);
         if (k == n - 1) set_in(1'b1, 1'b0);
      end
      step();
      chk_outs({tag, "_idle"}, 6'b000000);
      chk_cnt({tag, "_cnt"}, cnt_after);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RESETn = 1'b0;
      set_in(1'b1, 1'b0);
      #12;
      chk_outs("reset_outs", 6'b000000);
      chk_cnt("reset_cnt", 8'd0);
      @(negedge CLK);
      RESETn = 1'b1;
      step();
      step();
      chk_outs("idle_after_reset", 6'b000000);

      press_seq("short5", 5, 8'd1);
      press_seq("long20", 20, 8'd2);
      press_seq("thresh10", 10, 8'd3);
      press_seq("long11", 11, 8'd4);

      // Level/flag mismatch in both directions must read as released.
      set_in(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk_outs($sformatf("mismatch_a%0d", i), 6'b000000);
      end
      set_in(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_outs($sformatf("mismatch_b%0d", i), 6'b000000);
      end
      chk_cnt("mismatch_cnt", 8'd4);

      // One-cycle release between two presses.
      set_in(1'b0, 1'b1);
      step();
      chk_outs("repress_p1", 6'b100001);
      step();
      step();
      set_in(1'b1, 1'b0);
      step();
      chk_outs("repress_rel", 6'b011000);
      set_in(1'b0, 1'b1);
      step();
      chk_outs("repress_p2", 6'b100001);
      chk_cnt("repress_cnt", 8'd6);

      // Async reset while held: outputs clear immediately, no release events.
      step();
      step();
      chk_outs("pre_reset_hold", 6'b000001);
      RESETn = 1'b0;
      #1;
      chk_outs("async_reset_outs", 6'b000000);
      chk_cnt("async_reset_cnt", 8'd0);
      step();
      chk_outs("in_reset_outs", 6'b000000);
      @(negedge CLK);
      RESETn = 1'b1;
      step();
      chk_outs("post_reset_press", 6'b100001);
      chk_cnt("post_reset_cnt", 8'd1);
      set_in(1'b1, 1'b0);
      step();
      chk_outs("post_reset_rel", 6'b011000);

      // 255 more presses bring the counter from 1 around to 0.
      for (int i = 0; i < 254; i++) begin
         set_in(1'b0, 1'b1);
         step();
         set_in(1'b1, 1'b0);
         step();
      end
      step();
      chk_cnt("cnt_255", 8'd255);
      set_in(1'b0, 1'b1);
      step();
      chk_outs("wrap_press", 6'b100001);
      chk_cnt("cnt_wrap", 8'd0);
      set_in(1'b1, 1'b0);
      step();
      chk_outs("wrap_rel", 6'b011000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
